ramb_access_arbiter: RTL and testbench

- Sits between the core's load/store unit, a debug/boot loader, and port B of the 64-bit dual-port instruction/data RAM.
- Grants one requester at a time and converts each byte-addressed byte, half or word access into byte-lane-enabled doubleword RAM beats.
- Splits any access that straddles an 8-byte boundary into two beats.
- Assembles load data, masks it to the access size and sign-extends it before returning it.

---
 rtl/ramb_access_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_ramb_access_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramb_access_arbiter.sv
// Port-B arbiter for the 64-bit I/D RAM: core LSU vs debug loader.
// Turns byte/half/word accesses into lane-enabled doubleword beats.
module ramb_access_arbiter #(
    parameter int AW     = 14,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [31:0]   c_addr,
    input  logic [1:0]    c_size,
    input  logic          c_sext,
    input  logic [31:0]   c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [31:0]   c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [1:0]    d_size,
    input  logic          d_sext,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          ram_en,
    output logic [7:0]    ram_we,
    output logic          ram_ren,
    output logic [AW-1:0] ram_addr,
    output logic [63:0]   ram_wdata,
    input  logic [63:0]   ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t        r_state;
    state_t        w_next;
    logic          r_fav_d;
    logic          r_sel;
    logic          r_we;
    logic          r_sext;
    logic          r_beat;
    logic [2:0]    r_off;
    logic [1:0]    r_size;
    logic [AW-1:0] r_dw;
    logic [31:0]   r_wdata;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_rd0;
    logic [63:0]   r_rd1;
    logic [31:0]   r_c_rdata;
    logic [31:0]   r_d_rdata;

    logic          w_pick_d;
    logic          w_grant;
    logic          w_split;
    logic          w_more;
    logic          w_cnt_last;
    logic [15:0]   w_len16;
    logic [15:0]   w_lanes16;
    logic [7:0]    w_lanes;
    logic [95:0]   w_wide;
    logic [63:0]   w_beat_data;
    logic [AW-1:0] w_beat_addr;
    logic [127:0]  w_rdcat;
    logic [31:0]   w_raw;
    logic [31:0]   w_res;
    logic          w_unused;

    // Tie goes to whoever was not granted last; r_fav_d=0 favours core.
    assign w_pick_d = d_req & (~c_req | r_fav_d);
    assign w_grant  = (r_state == S_IDLE) & (c_req | d_req);

    assign w_len16 = (r_size == 2'd0) ? 16'h0001 :
                     (r_size == 2'd1) ? 16'h0003 : 16'h000F;
    assign w_lanes16 = w_len16 << r_off;
    assign w_split   = |w_lanes16[15:8];
    assign w_more    = w_split & ~r_beat;
    assign w_lanes   = r_beat ? w_lanes16[15:8] : w_lanes16[7:0];

    assign w_wide      = {64'd0, r_wdata} << {r_off, 3'b000};
    assign w_beat_data = r_beat ? {32'd0, w_wide[95:64]} : w_wide[63:0];
    assign w_beat_addr = r_beat ? r_dw + AW'(1) : r_dw;

    assign w_cnt_last = (r_cnt == CW'(RD_LAT - 1));

    assign w_rdcat = {r_rd1, r_rd0};
    assign w_raw   = w_rdcat[{1'b0, r_off, 3'b000} +: 32];

    assign w_unused = ^{c_addr[31:AW+3], d_addr[31:AW+3]};

    always_comb begin
        w_res = w_raw;
        unique case (r_size)
            2'd0:    w_res = {{24{r_sext & w_raw[7]}}, w_raw[7:0]};
            2'd1:    w_res = {{16{r_sext & w_raw[15]}}, w_raw[15:0]};
            default: w_res = w_raw;
        endcase
        if (r_we) begin
            w_res = '0;
        end
    end

    always_comb begin
        w_next    = r_state;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_ren   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    c_gnt  = rst_n & ~w_pick_d;
                    d_gnt  = rst_n & w_pick_d;
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_en    = 1'b1;
                ram_addr  = w_beat_addr;
                ram_wdata = w_beat_data;
                if (r_we) begin
                    ram_we = w_lanes;
                    w_next = w_more ? S_ISSUE : S_DONE;
                end else begin
                    ram_ren = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_cnt_last) begin
                    w_next = w_more ? S_ISSUE : S_DONE;
                end
            end
            S_DONE: begin
                c_rvalid = ~r_sel;
                d_rvalid = r_sel;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign c_rdata = (c_rvalid) ? w_res : r_c_rdata;
    assign d_rdata = (d_rvalid) ? w_res : r_d_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_fav_d   <= 1'b0;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_sext    <= 1'b0;
            r_beat    <= 1'b0;
            r_off     <= '0;
            r_size    <= '0;
            r_dw      <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_rd0     <= '0;
            r_rd1     <= '0;
            r_c_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_sel   <= w_pick_d;
                        r_fav_d <= ~w_pick_d;
                        r_beat  <= 1'b0;
                        r_cnt   <= '0;
                        if (w_pick_d) begin
                            r_we    <= d_we;
                            r_off   <= d_addr[2:0];
                            r_dw    <= d_addr[AW+2:3];
                            r_size  <= d_size;
                            r_sext  <= d_sext;
                            r_wdata <= d_wdata;
                        end else begin
                            r_we    <= c_we;
                            r_off   <= c_addr[2:0];
                            r_dw    <= c_addr[AW+2:3];
                            r_size  <= c_size;
                            r_sext  <= c_sext;
                            r_wdata <= c_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                    if (r_we) begin
                        r_beat <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_cnt_last) begin
                        if (r_beat) begin
                            r_rd1 <= ram_rdata;
                        end else begin
                            r_rd0 <= ram_rdata;
                        end
                        r_beat <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (r_sel) begin
                        r_d_rdata <= w_res;
                    end else begin
                        r_c_rdata <= w_res;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ramb_access_arbiter.sv
// Bench for ramb_access_arbiter: RAM model, byte-level golden memory,
// scoreboard of expected completions plus directed beat/latency checks.
module tb_ramb_access_arbiter;

    localparam int AW = 14;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req = 0, c_we = 0, c_sext = 0;
    logic [31:0]   c_addr = 0, c_wdata = 0;
    logic [1:0]    c_size = 0;
    logic          c_gnt, c_rvalid;
    logic [31:0]   c_rdata;
    logic          d_req = 0, d_we = 0, d_sext = 0;
    logic [31:0]   d_addr = 0, d_wdata = 0;
    logic [1:0]    d_size = 0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          ram_en, ram_ren;
    logic [7:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata = 0;

    always #5 clk = ~clk;

    ramb_access_arbiter #(.AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
        .c_size(c_size), .c_sext(c_sext), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
        .d_size(d_size), .d_sext(d_sext), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_ren(ram_ren),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    typedef struct {
        bit          port;
        logic [31:0] data;
    } exp_t;
    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic [7:0]  we;
        logic        ren;
        logic [63:0] wd;
    } beat_t;
    typedef struct {
        int          cyc;
        bit          port;
        logic [31:0] data;
    } rv_t;

    logic [63:0] mem [0:16383];
    logic [7:0]  gmem [0:131071];
    exp_t        sb[$];
    beat_t       beats[$];
    rv_t         rvs[$];
    bit          gnts[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic        s_c_gnt = 0, s_d_gnt = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(int x);
        return 8'((x * 37) + ((x >> 8) * 11) + 8'h5A);
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int gidx(logic [31:0] a, int i);
        return int'((a + 32'(i)) & 32'h1FFFF);
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a,
                                               logic [1:0] sz,
                                               logic sx);
        int n = nbytes(sz);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r[i*8 +: 8] = gmem[gidx(a, i)];
        if (sx && n == 1 && r[7]) r[31:8] = '1;
        if (sx && n == 2 && r[15]) r[31:16] = '1;
        return r;
    endfunction

    task automatic ram_init();
        logic [63:0] d2 = 64'h8877665544332211;
        for (int a = 0; a < 16384; a++) begin
            for (int b = 0; b < 8; b++) begin
                mem[a][b*8 +: 8] = pat(a * 8 + b);
                gmem[a * 8 + b] = pat(a * 8 + b);
            end
        end
        mem[2] = d2;
        for (int b = 0; b < 8; b++) gmem[16 + b] = d2[b*8 +: 8];
    endtask

    task automatic on_gnt(bit p);
        logic        we = p ? d_we : c_we;
        logic [31:0] a  = p ? d_addr : c_addr;
        logic [1:0]  sz = p ? d_size : c_size;
        logic        sx = p ? d_sext : c_sext;
        logic [31:0] wd = p ? d_wdata : c_wdata;
        if (we) begin
            for (int i = 0; i < nbytes(sz); i++)
                gmem[gidx(a, i)] = wd[i*8 +: 8];
            sb.push_back('{port: p, data: 32'd0});
        end else begin
            sb.push_back('{port: p, data: model_load(a, sz, sx)});
        end
    endtask

    task automatic got_rv(bit p, logic [31:0] d);
        exp_t e;
        rvs.push_back('{cyc: cyc, port: p, data: d});
        chk("rv_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rv_port", p, e.port);
            chk("rv_data", d, e.data);
        end
    endtask

    // One cycle: sample and model the RAM at negedge, return at posedge+1.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ram_en) begin
            beats.push_back('{cyc: cyc, addr: ram_addr, we: ram_we,
                              ren: ram_ren, wd: ram_wdata});
            if (ram_ren) ram_rdata = mem[ram_addr];
            for (int b = 0; b < 8; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] = ram_wdata[b*8 +: 8];
        end
        s_c_gnt = c_gnt;
        s_d_gnt = d_gnt;
        if (c_gnt && d_gnt) chk("dual_gnt", {c_gnt, d_gnt}, 2'b01);
        if (c_gnt) begin gnts.push_back(0); on_gnt(0); end
        if (d_gnt) begin gnts.push_back(1); on_gnt(1); end
        if (c_rvalid && d_rvalid) chk("dual_rv", {c_rvalid, d_rvalid}, 2'b01);
        if (c_rvalid) got_rv(0, c_rdata);
        if (d_rvalid) got_rv(1, d_rdata);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(bit p, bit we, logic [31:0] a, logic [1:0] sz,
                         bit sx, logic [31:0] wd, output int t);
        int k = 0;
        bit got = 0;
        if (p) begin
            d_we = we; d_addr = a; d_size = sz; d_sext = sx; d_wdata = wd;
            d_req = 1;
        end else begin
            c_we = we; c_addr = a; c_size = sz; c_sext = sx; c_wdata = wd;
            c_req = 1;
        end
        while (!got && k < 50) begin
            tick();
            k++;
            got = p ? s_d_gnt : s_c_gnt;
        end
        t = cyc;
        chk("gnt_wait", got, 1);
        c_req = 0;
        d_req = 0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (sb.size() > 0 && k < 100) begin
            tick();
            k++;
        end
        chk("done_wait", sb.size(), 0);
    endtask

    task automatic clr_logs();
        beats.delete();
        rvs.delete();
        gnts.delete();
    endtask

    initial begin
        int t;
        logic [31:0] e;
        ram_init();

        rst_n = 0;
        c_req = 1;
        tick();
        chk("rst_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid,
                        ram_en, ram_ren, ram_we}, 0);
        chk("rst_rdata", {c_rdata, d_rdata}, 0);
        chk("rst_raddr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        c_req = 0;
        rst_n = 1;
        tick();

        clr_logs();
        issue(0, 0, 32'h10, 2, 0, 0, t);
        wait_done();
        chk("ld_nbeats", beats.size(), 1);
        chk("ld_bcyc", beats[0].cyc, t + 1);
        chk("ld_baddr", beats[0].addr, 2);
        chk("ld_ren", beats[0].ren, 1);
        chk("ld_we", beats[0].we, 0);
        chk("ld_rvcyc", rvs[0].cyc, t + 3);
        chk("ld_data", rvs[0].data, 32'h44332211);

        clr_logs();
        issue(0, 1, 32'h0E, 2, 0, 32'hAABBCCDD, t);
        wait_done();
        chk("st_nbeats", beats.size(), 2);
        chk("st_b0cyc", beats[0].cyc, t + 1);
        chk("st_b0addr", beats[0].addr, 1);
        chk("st_b0we", beats[0].we, 8'hC0);
        chk("st_b0ren", beats[0].ren, 0);
        chk("st_b0wd", beats[0].wd, 64'hCCDD_0000_0000_0000);
        chk("st_b1cyc", beats[1].cyc, t + 2);
        chk("st_b1addr", beats[1].addr, 2);
        chk("st_b1we", beats[1].we, 8'h03);
        chk("st_b1wd", beats[1].wd, 64'h0000_0000_0000_AABB);
        chk("st_rvcyc", rvs[0].cyc, t + 3);
        clr_logs();
        issue(1, 0, 32'h0E, 2, 0, 0, t);
        wait_done();
        chk("st_readback", rvs[0].data, 32'hAABBCCDD);

        clr_logs();
        issue(0, 1, 32'h13, 0, 0, 32'h0000009C, t);
        wait_done();
        issue(0, 0, 32'h13, 0, 1, 0, t);
        wait_done();
        issue(0, 0, 32'h13, 0, 0, 0, t);
        wait_done();
        issue(0, 0, 32'h12, 1, 1, 0, t);
        wait_done();
        chk("sb_sext1", rvs[1].data, 32'hFFFFFF9C);
        chk("sb_sext0", rvs[2].data, 32'h0000009C);

        issue(1, 0, 32'h20, 2, 0, 0, t);
        wait_done();
        e = model_load(32'h10, 2, 0);
        clr_logs();
        c_we = 0; c_addr = 32'h10; c_size = 2; c_sext = 0;
        d_we = 0; d_addr = 32'h0E; d_size = 1; d_sext = 1;
        c_req = 1;
        d_req = 1;
        for (int k = 0; k < 100 && gnts.size() < 3; k++) tick();
        c_req = 0;
        d_req = 0;
        wait_done();
        chk("arb_ngnt", gnts.size(), 3);
        chk("arb_order", {gnts[0], gnts[1], gnts[2]}, 3'b010);
        chk("arb_nrv", rvs.size(), 3);
        chk("arb_rvord", {rvs[0].port, rvs[1].port, rvs[2].port}, 3'b010);
        chk("c_hold", c_rdata, e);

        clr_logs();
        e = {pat(0), pat(32'h1FFFF)} ;
        issue(0, 0, 32'h1FFFF, 1, 0, 0, t);
        wait_done();
        chk("wr_nbeats", beats.size(), 2);
        chk("wr_b0addr", beats[0].addr, 14'h3FFF);
        chk("wr_b1addr", beats[1].addr, 14'h0000);
        chk("wr_b1cyc", beats[1].cyc, t + 3);
        chk("wr_rvcyc", rvs[0].cyc, t + 5);
        chk("wr_data", rvs[0].data, e);
        clr_logs();
        issue(1, 1, 32'h1FFFF, 1, 0, 32'h0000BEEF, t);
        wait_done();
        chk("ws_b0", {beats[0].addr, beats[0].we}, {14'h3FFF, 8'h80});
        chk("ws_b0wd", beats[0].wd, 64'hEF00_0000_0000_0000);
        chk("ws_b1", {beats[1].addr, beats[1].we}, {14'h0000, 8'h01});
        chk("ws_b1wd", beats[1].wd, 64'h0000_0000_0000_00BE);
        clr_logs();
        issue(0, 0, 32'h1FFFF, 1, 1, 0, t);
        wait_done();
        chk("wr_sext", rvs[0].data, 32'hFFFFBEEF);

        clr_logs();
        issue(0, 0, 32'h1D, 2, 0, 0, t);
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_ctl", {c_gnt, d_gnt, c_rvalid, d_rvalid,
                            ram_en, ram_ren, ram_we}, 0);
        chk("mid_rst_rdata", {c_rdata, d_rdata}, 0);
        chk("mid_rst_ram", {ram_addr, ram_wdata[49:0]}, 0);
        sb.delete();
        tick();
        rst_n = 1;
        rvs.delete();
        repeat (4) tick();
        chk("no_rv_after_rst", rvs.size(), 0);
        clr_logs();
        c_we = 0; c_addr = 32'h08; c_size = 2; c_sext = 0;
        d_we = 0; d_addr = 32'h18; d_size = 2; d_sext = 0;
        c_req = 1;
        d_req = 1;
        for (int k = 0; k < 50 && gnts.size() < 1; k++) tick();
        c_req = 0;
        d_req = 0;
        wait_done();
        chk("rst_first_gnt", gnts.size() > 0 && gnts[0] == 0, 1);

        for (int i = 0; i < 24; i++) begin
            bit          p  = 1'($urandom_range(0, 1));
            bit          we = 1'($urandom_range(0, 1));
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            bit          sx = 1'($urandom_range(0, 1));
            logic [31:0] a  = ($urandom_range(0, 3) == 0) ?
                              32'h1FFF0 + $urandom_range(0, 15) :
                              32'($urandom_range(0, 63));
            issue(p, we, a, sz, sx, $urandom, t);
            wait_done();
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
